// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its MMIO window.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } st_size_e;

  localparam logic [11:0] OFF_LEDR   = 12'h000;
  localparam logic [11:0] OFF_HEX    = 12'h004;
  localparam logic [11:0] OFF_SW     = 12'h008;
  localparam logic [11:0] OFF_CYCLE  = 12'h00C;
  localparam logic [11:0] OFF_CMP    = 12'h010;
  localparam logic [11:0] OFF_STATUS = 12'h014;
  localparam logic [11:0] OFF_CTRL   = 12'h018;

  localparam int STAT_MATCH  = 0;
  localparam int STAT_ERR    = 1;
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_CNT_EN = 1;

  localparam logic [31:0] CMP_RST  = 32'hFFFF_FFFF;
  localparam logic [1:0]  CTRL_RST = 2'b10;

endpackage

// File: rtl/dmem_responder_mmio_regs.sv
// MMIO register window: LED/HEX outputs, switch synchroniser, cycle counter
// with compare flag, sticky error flag and interrupt output.
module mmio_regs
  import dmem_pkg::*;
#(
  parameter int SW_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [9:0]      woff_i,
  input  logic [31:0]     wdata_i,
  input  logic            err_set_i,
  input  logic [SW_W-1:0] sw_i,
  output logic [31:0]     rdata_o,
  output logic [31:0]     ledr_o,
  output logic [31:0]     hex_o,
  output logic            irq_o
);

  logic [31:0]     ledr_q, ledr_d, hex_q, hex_d, cycle_q, cycle_d, cmp_q, cmp_d;
  logic            match_q, match_d, err_q, err_d;
  logic            irq_en_q, irq_en_d, cnt_en_q, cnt_en_d;
  logic [SW_W-1:0] sw_s1_q, sw_s2_q;
  logic            stat_wr;

  assign stat_wr = we_i && (woff_i == OFF_STATUS[11:2]);

  always_comb begin
    ledr_d   = ledr_q;
    hex_d    = hex_q;
    cmp_d    = cmp_q;
    irq_en_d = irq_en_q;
    cnt_en_d = cnt_en_q;
    cycle_d  = cnt_en_q ? cycle_q + 32'd1 : cycle_q;
    if (we_i) begin
      case (woff_i)
        OFF_LEDR[11:2]:  ledr_d = wdata_i;
        OFF_HEX[11:2]:   hex_d = wdata_i;
        OFF_CYCLE[11:2]: cycle_d = wdata_i;
        OFF_CMP[11:2]:   cmp_d = wdata_i;
        OFF_CTRL[11:2]: begin
          irq_en_d = wdata_i[CTRL_IRQ_EN];
          cnt_en_d = wdata_i[CTRL_CNT_EN];
        end
        default: ;
      endcase
    end
    // A set event in the same cycle as a W1C keeps the flag set.
    match_d = (cycle_q == cmp_q) | (match_q & ~(stat_wr & wdata_i[STAT_MATCH]));
    err_d   = err_set_i | (err_q & ~(stat_wr & wdata_i[STAT_ERR]));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ledr_q   <= '0;
      hex_q    <= '0;
      cycle_q  <= '0;
      cmp_q    <= CMP_RST;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= CTRL_RST[CTRL_IRQ_EN];
      cnt_en_q <= CTRL_RST[CTRL_CNT_EN];
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      ledr_q   <= ledr_d;
      hex_q    <= hex_d;
      cycle_q  <= cycle_d;
      cmp_q    <= cmp_d;
      match_q  <= match_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
      cnt_en_q <= cnt_en_d;
      sw_s1_q  <= sw_i;
      sw_s2_q  <= sw_s1_q;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (woff_i)
      OFF_LEDR[11:2]:   rdata_o = ledr_q;
      OFF_HEX[11:2]:    rdata_o = hex_q;
      OFF_SW[11:2]:     rdata_o = {{(32-SW_W){1'b0}}, sw_s2_q};
      OFF_CYCLE[11:2]:  rdata_o = cycle_q;
      OFF_CMP[11:2]:    rdata_o = cmp_q;
      OFF_STATUS[11:2]: rdata_o = {30'd0, err_q, match_q};
      OFF_CTRL[11:2]:   rdata_o = {30'd0, cnt_en_q, irq_en_q};
      default: ;
    endcase
  end

  assign ledr_o = ledr_q;
  assign hex_o  = hex_q;
  assign irq_o  = match_q & irq_en_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores, address decode,
// zero-latency read mux and the MMIO register window.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int          SW_W        = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWriteM,
  input  logic [1:0]      StSizeM,
  input  logic [31:0]     ALUResultM,
  input  logic [31:0]     WriteDataM,
  output logic [31:0]     ReadDataM,
  input  logic [SW_W-1:0] i_sw,
  output logic [31:0]     o_ledr,
  output logic [31:0]     o_hex,
  output logic            o_irq
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             ram_hit, mmio_hit, misal, size_ok, ram_we, mmio_we, err_set;
  logic [3:0]       be;
  logic [31:0]      wdat, mmio_rdata;
  st_size_e         sz;

  assign sz       = st_size_e'(StSizeM);
  assign idx      = ALUResultM[IDX_W+1:2];
  assign ram_hit  = {1'b0, ALUResultM} < RAM_BYTES;
  assign mmio_hit = ALUResultM[31:12] == MMIO_BASE[31:12];

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be      = 4'b0000;
    wdat    = WriteDataM;
    misal   = 1'b0;
    size_ok = 1'b1;
    case (sz)
      SZ_B: begin
        be   = 4'b0001 << ALUResultM[1:0];
        wdat = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdat  = {2{WriteDataM[15:0]}};
        misal = ALUResultM[0];
      end
      SZ_W: begin
        be    = 4'b1111;
        misal = |ALUResultM[1:0];
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign ram_we  = MemWriteM & ram_hit & size_ok & ~misal;
  assign mmio_we = MemWriteM & mmio_hit & (sz == SZ_W) & ~misal;
  assign err_set = MemWriteM & size_ok &
                   (((ram_hit | mmio_hit) & misal) | (mmio_hit & (sz != SZ_W)));

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  mmio_regs #(.SW_W(SW_W)) u_mmio (
    .clk_i     (clk),
    .rst_ni    (rst),
    .we_i      (mmio_we),
    .woff_i    (ALUResultM[11:2]),
    .wdata_i   (WriteDataM),
    .err_set_i (err_set),
    .sw_i      (i_sw),
    .rdata_o   (mmio_rdata),
    .ledr_o    (o_ledr),
    .hex_o     (o_hex),
    .irq_o     (o_irq)
  );

  always_comb begin
    ReadDataM = '0;
    if (ram_hit)       ReadDataM = mem[idx];
    else if (mmio_hit) ReadDataM = mmio_rdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  localparam logic [31:0] MM = 32'h1000_0000;
  localparam logic [31:0] A_LEDR = MM + 32'h00, A_HEX = MM + 32'h04, A_SW = MM + 32'h08;
  localparam logic [31:0] A_CYC = MM + 32'h0C, A_CMP = MM + 32'h10;
  localparam logic [31:0] A_STAT = MM + 32'h14, A_CTRL = MM + 32'h18;
  localparam logic [1:0]  B = 2'b00, H = 2'b01, W = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWriteM = 1'b0;
  logic [1:0]  StSizeM = 2'b10;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic [9:0]  i_sw = '0;
  logic [31:0] o_ledr, o_hex;
  logic        o_irq;

  int checks = 0;
  int failures = 0;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .StSizeM    (StSizeM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .i_sw       (i_sw),
    .o_ledr     (o_ledr),
    .o_hex      (o_hex),
    .o_irq      (o_irq)
  );

  always #5 clk = ~clk;

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    ALUResultM = a; WriteDataM = d; StSizeM = sz; MemWriteM = 1'b1;
    @(posedge clk);
    #1 MemWriteM = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    ALUResultM = a;
    #1 d = ReadDataM;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    #1 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (o_ledr !== 32'h0) begin failures++; $display("FAIL rst_ledr got %h want %h", o_ledr, 32'h0); end
    checks++; if (o_hex !== 32'h0) begin failures++; $display("FAIL rst_hex got %h want %h", o_hex, 32'h0); end
    checks++; if (o_irq !== 1'b0) begin failures++; $display("FAIL rst_irq got %b want 0", o_irq); end
    load(A_CMP, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_cmp got %h want %h", r, 32'hFFFF_FFFF); end
    load(A_CTRL, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL rst_ctrl got %h want %h", r, 32'h2); end
    load(A_STAT, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rst_status got %h want %h", r, 32'h0); end
    load(A_CYC, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rst_cycle got %h want %h", r, 32'h0); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_lanes();
    logic [31:0] r;
    store(32'h10, 32'hDEAD_BEEF, W);
    store(32'h11, 32'h1234_5655, B);
    load(32'h10, r);
    checks++; if (r !== 32'hDEAD_55EF) begin failures++; $display("FAIL byte_lane1 got %h want %h", r, 32'hDEAD_55EF); end
    store(32'h12, 32'h9999_A5A5, H);
    load(32'h10, r);
    checks++; if (r !== 32'hA5A5_55EF) begin failures++; $display("FAIL half_upper got %h want %h", r, 32'hA5A5_55EF); end
    load(32'h13, r);
    checks++; if (r !== 32'hA5A5_55EF) begin failures++; $display("FAIL unaligned_read got %h want %h", r, 32'hA5A5_55EF); end
    @(negedge clk);
    ALUResultM = 32'h10; WriteDataM = 32'h0102_0304; StSizeM = W; MemWriteM = 1'b1;
    #1 r = ReadDataM;
    checks++; if (r !== 32'hA5A5_55EF) begin failures++; $display("FAIL same_cycle_old got %h want %h", r, 32'hA5A5_55EF); end
    @(posedge clk); #1 MemWriteM = 1'b0;
    load(32'h10, r);
    checks++; if (r !== 32'h0102_0304) begin failures++; $display("FAIL word_commit got %h want %h", r, 32'h0102_0304); end
    store(32'h13, 32'h0000_00AB, B);
    load(32'h10, r);
    checks++; if (r !== 32'hAB02_0304) begin failures++; $display("FAIL byte_lane3 got %h want %h", r, 32'hAB02_0304); end
  endtask

  task automatic test_misaligned();
    logic [31:0] r;
    store(32'h04, 32'h1234_5678, W);
    store(32'h08, 32'h9ABC_DEF0, W);
    store(32'h06, 32'hFFFF_FFFF, W);
    load(32'h04, r);
    checks++; if (r !== 32'h1234_5678) begin failures++; $display("FAIL misal_word got %h want %h", r, 32'h1234_5678); end
    store(32'h0B, 32'h0000_1111, H);
    load(32'h08, r);
    checks++; if (r !== 32'h9ABC_DEF0) begin failures++; $display("FAIL misal_half got %h want %h", r, 32'h9ABC_DEF0); end
    load(A_STAT, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL err_set got %h want %h", r, 32'h2); end
    store(A_STAT, 32'h2, W);
    load(A_STAT, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL err_w1c got %h want %h", r, 32'h0); end
    store(A_LEDR, 32'h0000_0077, B);
    load(A_LEDR, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL mmio_byte_ignored got %h want %h", r, 32'h0); end
    load(A_STAT, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL mmio_byte_err got %h want %h", r, 32'h2); end
    store(A_STAT, 32'h2, W);
    store(A_HEX, 32'h7654_3210, W);
    checks++; if (o_hex !== 32'h7654_3210) begin failures++; $display("FAIL hex_out got %h want %h", o_hex, 32'h7654_3210); end
    load(A_HEX, r);
    checks++; if (r !== 32'h7654_3210) begin failures++; $display("FAIL hex_read got %h want %h", r, 32'h7654_3210); end
  endtask

  task automatic test_irq();
    logic [31:0] r;
    store(A_CTRL, 32'h0, W);
    store(A_CYC, 32'h0, W);
    store(A_CMP, 32'h5, W);
    store(A_STAT, 32'h3, W);
    load(A_STAT, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL irq_pre_status got %h want %h", r, 32'h0); end
    store(A_CTRL, 32'h3, W);
    checks++; if (o_irq !== 1'b0) begin failures++; $display("FAIL irq_early got %b want 0", o_irq); end
    repeat (5) @(posedge clk);
    load(A_CYC, r);
    checks++; if (r !== 32'h5) begin failures++; $display("FAIL irq_cycle5 got %h want %h", r, 32'h5); end
    checks++; if (o_irq !== 1'b0) begin failures++; $display("FAIL irq_at_eq got %b want 0", o_irq); end
    store(A_STAT, 32'h1, W);
    checks++; if (o_irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got %b want 1", o_irq); end
    load(A_STAT, r);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL irq_status got %h want %h", r, 32'h1); end
    store(A_STAT, 32'h1, W);
    checks++; if (o_irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got %b want 0", o_irq); end
  endtask

  task automatic test_cycle();
    logic [31:0] r;
    store(A_CTRL, 32'h2, W);
    store(A_CYC, 32'hFFFF_FFFE, W);
    load(A_CYC, r);
    checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL cyc_load got %h want %h", r, 32'hFFFF_FFFE); end
    @(posedge clk);
    load(A_CYC, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cyc_max got %h want %h", r, 32'hFFFF_FFFF); end
    @(posedge clk);
    load(A_CYC, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL cyc_wrap got %h want %h", r, 32'h0); end
    store(A_CYC, 32'h100, W);
    load(A_CYC, r);
    checks++; if (r !== 32'h100) begin failures++; $display("FAIL cyc_store got %h want %h", r, 32'h100); end
    @(posedge clk);
    load(A_CYC, r);
    checks++; if (r !== 32'h101) begin failures++; $display("FAIL cyc_after_store got %h want %h", r, 32'h101); end
  endtask

  task automatic test_sw_unmapped();
    logic [31:0] r;
    load(A_SW, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL sw_idle got %h want %h", r, 32'h0); end
    @(negedge clk) i_sw = 10'h3FF;
    @(posedge clk);
    load(A_SW, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL sw_edge1 got %h want %h", r, 32'h0); end
    @(posedge clk);
    load(A_SW, r);
    checks++; if (r !== 32'h3FF) begin failures++; $display("FAIL sw_edge2 got %h want %h", r, 32'h3FF); end
    store(32'h0, 32'h0BAD_F00D, W);
    load(32'h2000_0000, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL unmapped_read got %h want %h", r, 32'h0); end
    store(32'h2000_0000, 32'hCAFE_BABE, W);
    load(32'h0, r);
    checks++; if (r !== 32'h0BAD_F00D) begin failures++; $display("FAIL unmapped_store got %h want %h", r, 32'h0BAD_F00D); end
    load(32'h2000, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL ram_end_read got %h want %h", r, 32'h0); end
    store(32'h2000, 32'h5A5A_5A5A, W);
    load(32'h0, r);
    checks++; if (r !== 32'h0BAD_F00D) begin failures++; $display("FAIL ram_end_store got %h want %h", r, 32'h0BAD_F00D); end
    store(32'h1FFC, 32'h600D_CAFE, W);
    load(32'h1FFC, r);
    checks++; if (r !== 32'h600D_CAFE) begin failures++; $display("FAIL ram_last got %h want %h", r, 32'h600D_CAFE); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    store(A_LEDR, 32'hF0, W);
    checks++; if (o_ledr !== 32'hF0) begin failures++; $display("FAIL ledr_out got %h want %h", o_ledr, 32'hF0); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (o_ledr !== 32'h0) begin failures++; $display("FAIL async_ledr got %h want %h", o_ledr, 32'h0); end
    load(A_CMP, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL async_cmp got %h want %h", r, 32'hFFFF_FFFF); end
    load(32'h10, r);
    checks++; if (r !== 32'hAB02_0304) begin failures++; $display("FAIL ram_kept got %h want %h", r, 32'hAB02_0304); end
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_misaligned();
    test_irq();
    test_cycle();
    test_sw_unmapped();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the processor's data-memory port: accepts address, write data and store strobe from the Memory stage, and returns ReadDataM combinationally in the same cycle.
- Contains a word-organised data RAM with byte-lane stores, plus a small MMIO register window: LEDs, 7-segment, synchronised switches, free-running cycle counter with compare/interrupt, and a status register.
- Sits beside the processor in the SoC top, in place of the bare data memory.

Parameters:
- DEPTH_WORDS, 2048, number of 32-bit RAM words; RAM occupies 0x0000_0000 .. DEPTH_WORDS*4-1.
- MMIO_BASE, 32'h1000_0000, base address of the register window (4 KiB, decoded on addr[31:12]).
- SW_W, 10, width of switch input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemWriteM  in  1  store strobe from M stage.
- StSizeM  in  2  store size: 00 byte, 01 half, 10 word, 11 reserved (store ignored). Tie to 10 for word-only cores.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- ReadDataM  out  32  aligned word at {addr[31:2],2'b00}; the processor performs load extraction and extension.
- i_sw  in  SW_W  asynchronous switch inputs.
- o_ledr  out  32  LED register.
- o_hex  out  32  7-segment register.
- o_irq  out  1  STATUS.match AND CTRL.irq_en.

Behaviour:
- Reads are combinational, zero latency. Address decode:
  - RAM hit: addr < DEPTH_WORDS*4.
  - MMIO hit: addr[31:12] == MMIO_BASE[31:12].
  - Anything else (unmapped): reads 0, stores ignored.
- Writes commit on the rising clk edge when MemWriteM=1; a same-cycle read returns the old value.
- Byte-lane stores:
  - Byte: lane addr[1:0]; data WriteDataM[7:0].
  - Half: lane addr[1]; data WriteDataM[15:0]; addr[0]=1 is misaligned.
  - Word: addr[1:0]!=0 is misaligned.
  - A misaligned store writes nothing and sets STATUS.err, which is sticky.
  - MMIO registers accept word stores only. A byte or half store to MMIO is ignored and sets STATUS.err.
- MMIO offsets:
  - 0x00 LEDR: RW.
  - 0x04 HEX: RW.
  - 0x08 SW: RO, zero-extended, via a 2-flop synchroniser, so 2-cycle input latency.
  - 0x0C CYCLE: RW.
  - 0x10 CMP: RW.
  - 0x14 STATUS: bit0 match, bit1 err, both W1C.
  - 0x18 CTRL: bit0 irq_en, bit1 cnt_en.
  - Other offsets read 0, writes ignored.
- CYCLE counter:
  - Increments by 1 every cycle when cnt_en=1 and wraps from 0xFFFF_FFFF to 0.
  - A store to CYCLE in the same cycle loads the written value with no +1 applied that cycle.
- match flag:
  - Set on the cycle after the registered CYCLE equals CMP, i.e. the compare is evaluated on current register values.
  - A W1C write coinciding with a set event leaves the flag set (set wins).
  - Same rule for err.
- Reset (rst=0, asynchronous):
  - LEDR=0, HEX=0, CYCLE=0, CMP=32'hFFFF_FFFF, STATUS=0, CTRL=2'b10 (counter running, irq off), synchroniser flops=0.
  - Outputs follow: o_ledr=0, o_hex=0, o_irq=0.
  - RAM contents are not reset.
  - Reset asserted mid-store aborts the store. RAM may or may not hold the new word; registers hold their reset values.
- No state machine beyond the counter/flag logic; no stalls are generated (the responder is always ready).

Decomposition:
- Package dmem_pkg:
  - st_size_e enum (SZ_B, SZ_H, SZ_W).
  - MMIO offset localparams (OFF_LEDR..OFF_CTRL).
  - STATUS/CTRL bit indices.
  - CMP reset constant.
- One sub-module, mmio_regs: register file, counter, compare, synchroniser, irq.
- dmem_responder holds the RAM, address decode, byte-enable generation and the read mux.

Test Plan:
- Store word 0xDEADBEEF @0x10, then byte 0x55 @0x11 and half 0xA5A5 @0x12 -> read @0x10 returns 0xA5A555EF.
- Word store @0x06 and half store @0x0B -> RAM unchanged, STATUS reads 0x2; write 0x2 to STATUS -> reads 0x0.
- CTRL=0x3, CMP=5, CYCLE written 0 -> o_irq rises exactly on the cycle after CYCLE==5; W1C of bit0 on the set cycle leaves o_irq=1.
- CYCLE written 0xFFFF_FFFE -> reads 0xFFFF_FFFF then 0x0000_0000 on subsequent cycles; a store of 0x100 while counting reads 0x100 on the next cycle.
- i_sw toggles 0x000->0x3FF -> SW read changes on the 2nd edge; reads @0x2000_0000 return 0 and stores there have no effect.
- Assert rst low asynchronously between edges after writing LEDR=0xF0 -> o_ledr=0 immediately, CMP reads 0xFFFF_FFFF, previously written RAM word still readable.
